// File: rtl/cache_refill_ctrl_pkg.sv
// Shared address-field layout, FSM state encoding and line-alignment helper
// for the cache lookup/refill controller.
package cache_pkg;

   localparam int ADDR_W    = 32;
   localparam int HALT_W    = 20;
   localparam int MAIN_W    = 4;
   localparam int INDEX_W   = 4;
   localparam int WORD_W    = 2;
   localparam int HALT_LSB  = 12;
   localparam int MAIN_LSB  = 8;
   localparam int INDEX_LSB = 4;

   localparam logic [ADDR_W-1:0] LINE_ALIGN_MASK = 32'hFFFF_FFF0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_MISS_REQ,
      S_REFILL,
      S_TAG_WRITE,
      S_RESP
   } state_t;

   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
      return addr & LINE_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Bundle of CPU request, tag/valid array, memory and data-array signals.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid holds its payload until then.
interface cache_refill_if
   import cache_pkg::*;
#(
   parameter int NUM_SETS = 16
);
   logic                reqValid;
   logic                reqReady;
   logic [ADDR_W-1:0]   reqAddr;
   logic                selValid;
   logic [MAIN_W-1:0]   selMainTag;
   logic [HALT_W-1:0]   selHaltTag;
   logic [INDEX_W-1:0]  lookupIndex;
   logic                memReqValid;
   logic                memReqReady;
   logic [ADDR_W-1:0]   memReqAddr;
   logic                memRspValid;
   logic [31:0]         memRspData;
   logic                dataWrite;
   logic [WORD_W-1:0]   dataWordSel;
   logic [31:0]         dataOut;
   logic                regWrite;
   logic [NUM_SETS-1:0] decOut;
   logic [MAIN_W-1:0]   inpMainTag;
   logic [HALT_W-1:0]   inpHaltTag;
   logic                validWrite;
   logic                respValid;
   logic                respHit;
   logic                respErr;
   state_t              dbgState;

   modport slave (
      input  reqValid, reqAddr, selValid, selMainTag, selHaltTag,
             memReqReady, memRspValid, memRspData,
      output reqReady, lookupIndex, memReqValid, memReqAddr,
             dataWrite, dataWordSel, dataOut, regWrite, decOut,
             inpMainTag, inpHaltTag, validWrite, respValid, respHit, respErr,
             dbgState
   );

   modport master (
      output reqValid, reqAddr, selValid, selMainTag, selHaltTag,
             memReqReady, memRspValid, memRspData,
      input  reqReady, lookupIndex, memReqValid, memReqAddr,
             dataWrite, dataWordSel, dataOut, regWrite, decOut,
             inpMainTag, inpHaltTag, validWrite, respValid, respHit, respErr,
             dbgState
   );
endinterface

// File: rtl/cache_refill_ctrl_dec.sv
// 4-to-16 one-hot set decoder, shared by the tag-array and data-array write paths.
module onehot_dec4to16 (
   input  logic        en_i,
   input  logic [3:0]  idx_i,
   output logic [15:0] dec_o
);
   always_comb begin
      dec_o = '0;
      if (en_i) dec_o[idx_i] = 1'b1;
   end
endmodule

// File: rtl/cache_refill_ctrl.sv
// Single-outstanding lookup/refill controller: tag compare, line fetch over
// valid/ready, word-by-word data write, then tag install and a one-cycle response.
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int NUM_SETS   = 16,
   parameter int LINE_WORDS = 4,
   parameter int TIMEOUT    = 255
) (
   input logic           clk,
   input logic           reset,
   cache_refill_if.slave bus
);
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
   localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(LINE_WORDS - 1);

   if (NUM_SETS != 16) begin : g_bad_sets
      $error("cache_refill_ctrl: NUM_SETS must be 16");
   end
   if (LINE_WORDS != 4) begin : g_bad_words
      $error("cache_refill_ctrl: LINE_WORDS must be 4");
   end

   state_t             state_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [WORD_W-1:0]  word_cnt_q;
   logic [TMR_W-1:0]   timer_q;
   logic               req_ready_q;
   logic               mem_req_valid_q;
   logic               reg_write_q;
   logic               valid_write_q;
   logic               resp_valid_q;
   logic               resp_hit_q;
   logic               resp_err_q;
   logic               hit;
   logic               dec_en;

   assign hit = bus.selValid
              & (bus.selHaltTag == addr_q[HALT_LSB +: HALT_W])
              & (bus.selMainTag == addr_q[MAIN_LSB +: MAIN_W]);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         addr_q          <= '0;
         word_cnt_q      <= '0;
         timer_q         <= '0;
         req_ready_q     <= 1'b1;
         mem_req_valid_q <= 1'b0;
         reg_write_q     <= 1'b0;
         valid_write_q   <= 1'b0;
         resp_valid_q    <= 1'b0;
         resp_hit_q      <= 1'b0;
         resp_err_q      <= 1'b0;
      end else begin
         reg_write_q   <= 1'b0;
         valid_write_q <= 1'b0;
         resp_valid_q  <= 1'b0;
         resp_hit_q    <= 1'b0;
         resp_err_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.reqValid) begin
                  addr_q      <= bus.reqAddr;
                  req_ready_q <= 1'b0;
                  state_q     <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (hit) begin
                  resp_valid_q <= 1'b1;
                  resp_hit_q   <= 1'b1;
                  state_q      <= S_RESP;
               end else begin
                  mem_req_valid_q <= 1'b1;
                  timer_q         <= '0;
                  state_q         <= S_MISS_REQ;
               end
            end
            S_MISS_REQ: begin
               if (bus.memReqReady) begin
                  mem_req_valid_q <= 1'b0;
                  word_cnt_q      <= '0;
                  timer_q         <= '0;
                  state_q         <= S_REFILL;
               end else if (timer_q == TMR_LAST) begin
                  mem_req_valid_q <= 1'b0;
                  timer_q         <= '0;
                  resp_valid_q    <= 1'b1;
                  resp_err_q      <= 1'b1;
                  state_q         <= S_RESP;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            S_REFILL: begin
               if (bus.memRspValid) begin
                  word_cnt_q <= word_cnt_q + 1'b1;
                  timer_q    <= '0;
                  if (word_cnt_q == WORD_LAST) begin
                     reg_write_q   <= 1'b1;
                     valid_write_q <= 1'b1;
                     state_q       <= S_TAG_WRITE;
                  end
               end else if (timer_q == TMR_LAST) begin
                  // Words already written stay in the data array; the line is never marked valid.
                  timer_q      <= '0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  state_q      <= S_RESP;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            S_TAG_WRITE: begin
               resp_valid_q <= 1'b1;
               state_q      <= S_RESP;
            end
            S_RESP: begin
               req_ready_q <= 1'b1;
               state_q     <= S_IDLE;
            end
            default: begin
               req_ready_q <= 1'b1;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign dec_en = (state_q == S_REFILL) || (state_q == S_TAG_WRITE);

   onehot_dec4to16 u_dec (
      .en_i  (dec_en),
      .idx_i (addr_q[INDEX_LSB +: INDEX_W]),
      .dec_o (bus.decOut)
   );

   // Data-array writes follow memRspValid combinationally so each word lands in its own arrival cycle.
   assign bus.dataWrite   = (state_q == S_REFILL) && bus.memRspValid;
   assign bus.dataWordSel = word_cnt_q;
   assign bus.dataOut     = bus.dataWrite ? bus.memRspData : '0;

   assign bus.reqReady    = req_ready_q;
   assign bus.lookupIndex = addr_q[INDEX_LSB +: INDEX_W];
   assign bus.memReqValid = mem_req_valid_q;
   assign bus.memReqAddr  = line_align(addr_q);
   assign bus.regWrite    = reg_write_q;
   assign bus.validWrite  = valid_write_q;
   assign bus.inpMainTag  = reg_write_q ? addr_q[MAIN_LSB +: MAIN_W] : '0;
   assign bus.inpHaltTag  = reg_write_q ? addr_q[HALT_LSB +: HALT_W] : '0;
   assign bus.respValid   = resp_valid_q;
   assign bus.respHit     = resp_hit_q;
   assign bus.respErr     = resp_err_q;
   assign bus.dbgState    = state_q;

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Lookup and refill controller that sits directly upstream of the main/halt tag arrays and the line data array. It accepts one CPU read request at a time and checks it against the tag and valid state of the indexed set. On a miss it fetches the line from memory over a valid/ready handshake. It then drives the tag-array write port (regWrite, one-hot set select, 4-bit main tag, 20-bit halt tag) to install the new tag.

Parameters:
NUM_SETS, 16, number of sets; one-hot decOut width. Only 16 is legal (elaboration check).
LINE_WORDS, 4, 32-bit words per line. Only 4 is legal (elaboration check).
TIMEOUT, 255, maximum idle cycles allowed in MISS_REQ or REFILL before the request is aborted with an error.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
reqValid  in  1  CPU request valid
reqReady  out  1  controller can accept a request
reqAddr  in  32  byte address; haltTag=[31:12], mainTag=[11:8], index=[7:4], word=[3:2]
selValid  in  1  valid bit of the indexed set, from the valid array
selMainTag  in  4  stored main tag of the indexed set
selHaltTag  in  20  stored halt tag of the indexed set
lookupIndex  out  4  set index presented to the arrays (latched request index)
memReqValid  out  1  line-fetch request
memReqReady  in  1  memory accepts the request
memReqAddr  out  32  line-aligned address, {addr[31:4],4'b0}
memRspValid  in  1  one refill word is present
memRspData  in  32  refill word
dataWrite  out  1  data-array word write enable
dataWordSel  out  2  word offset being written
dataOut  out  32  word to write (memRspData passed through)
regWrite  out  1  tag-array write enable
decOut  out  NUM_SETS  one-hot set select
inpMainTag  out  4  main tag to write
inpHaltTag  out  20  halt tag to write
validWrite  out  1  sets the valid bit of the selected set
respValid  out  1  single-cycle completion pulse
respHit  out  1  request hit (valid with respValid)
respErr  out  1  refill timed out (valid with respValid)

Behaviour:
- States: IDLE, LOOKUP, MISS_REQ, REFILL, TAG_WRITE, RESP.
- Reset state: IDLE.
- Reset values: all outputs 0 except reqReady=1; wordCnt=0; timer=0; the latched address register is cleared to 0.
- IDLE:
  - reqReady=1.
  - On reqValid, latch reqAddr and go to LOOKUP.
- LOOKUP (exactly 1 cycle):
  - hit = selValid & (selHaltTag==addr[31:12]) & (selMainTag==addr[11:8]).
  - hit -> RESP with respHit=1; miss -> MISS_REQ.
- MISS_REQ:
  - memReqValid=1 and memReqAddr held stable until memReqReady.
  - On handshake go to REFILL with wordCnt=0 and timer=0.
- REFILL:
  - decOut = one-hot(index) throughout.
  - Each cycle memRspValid=1: dataWrite=1, dataWordSel=wordCnt, dataOut=memRspData, wordCnt++.
  - On memRspValid with wordCnt==3, go to TAG_WRITE; wordCnt wraps to 0.
  - Cycles with memRspValid=0 insert no write.
- TAG_WRITE (exactly 1 cycle):
  - regWrite=1, validWrite=1, decOut=one-hot(index), inpMainTag=addr[11:8], inpHaltTag=addr[31:12].
  - Then go to RESP with respHit=0.
- RESP (1 cycle): respValid=1, then go to IDLE.
- Latency:
  - Hit: request accepted at edge T -> respValid high in cycle T+2.
  - Miss: tag write occurs in the cycle after the 4th refill word; respValid is high in the following cycle.
- Timer:
  - Counts cycles in MISS_REQ/REFILL with no handshake/word; resets on each handshake/word.
  - When timer reaches TIMEOUT: go to RESP with respErr=1, respHit=0; no tag write, no validWrite.
  - Data words already written remain, but the line stays invalid.
- Signals outside their states:
  - reqReady=0 in every state except IDLE; reqValid is ignored there.
  - memRspValid outside REFILL is ignored.
  - regWrite/validWrite never assert outside TAG_WRITE.
  - decOut is all-zero outside REFILL/TAG_WRITE.
- Reset in any state (including mid-REFILL): next cycle is IDLE with reset values; no partial tag write is ever issued.
- lookupIndex = latched addr[7:4] in all states.

Decomposition:
- Package cache_pkg: address-field widths and offsets (HALT_W=20, MAIN_W=4, INDEX_W=4, WORD_W=2), the state enum, and the line-alignment constant.
- One natural sub-module: onehot_dec4to16, shared with the data-array write path.

Test Plan:
- Hit: selValid=1, selHaltTag=20'hABCDE, selMainTag=4'h5; request 32'hABCDE5_34 -> respValid at T+2, respHit=1, no memReqValid, no regWrite.
- Cold miss on addr 32'h12345_6_7_8 with selValid=0 -> memReqAddr=32'h12345670; 4 words 0x11..0x44 with gaps -> dataWordSel 0,1,2,3 in order; then regWrite=1, decOut=16'h0080, inpHaltTag=20'h12345, inpMainTag=4'h6; respHit=0.
- Tag mismatch: selValid=1 with the halt tag matching but the main tag differing -> treated as a miss and refill issued.
- memReqReady held low for 255 cycles -> respErr=1, no regWrite/validWrite, return to IDLE.
- reset asserted after the 2nd refill word -> IDLE, reqReady=1, a new request is accepted, and no tag write is observed.
- reqValid held high during a refill -> the second request is not accepted until the first respValid, then accepted the cycle after.
